mc_ctrl_fsm: RTL and testbench

//  Multicycle MIPS main control FSM with a memory ready/wait handshake.

---
 rtl/mc_ctrl_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM with memory ready/wait handshake.
// Sequences fetch/decode/execute/memory/writeback; Moore outputs are
// registered alongside the state, while the write strobes that depend on
// mem_ready (and the decode/timeout pulses) are qualified combinationally.
module mc_ctrl_fsm #(
    parameter int SUPPORT_ADDI = 1,
    parameter int SUPPORT_JUMP = 1,
    parameter int MEM_TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcwrite,
    output logic       branch,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    // Moore control word, one field per datapath control.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctl_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state;
    state_t        nxt;
    ctl_t          ctl;
    logic [CW-1:0] wait_cnt;
    logic          wait_st;
    logic          tmo_hit;
    logic          bad_op;

    // Moore decode of a state; unused encodings yield an all-zero word.
    function automatic ctl_t moore(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD, MEMWR: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: c.regwrite = 1'b1;
            JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Timeout fires on the N-th consecutive not-ready cycle of a memory state;
    // a ready on that same cycle takes precedence.
    always_comb begin
        wait_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
        tmo_hit = (MEM_TIMEOUT > 0) && wait_st && !mem_ready && (wait_cnt == CNT_LAST);
    end

    // Next-state selection and opcode legality check.
    always_comb begin
        nxt    = FETCH;
        bad_op = 1'b0;
        case (state)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYP:      nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI: begin
                        if (SUPPORT_ADDI != 0) nxt = ADDIEX;
                        else                   bad_op = 1'b1;
                    end
                    OP_J: begin
                        if (SUPPORT_JUMP != 0) nxt = JUMP;
                        else                   bad_op = 1'b1;
                    end
                    default: bad_op = 1'b1;
                endcase
            end
            MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready)     nxt = MEMWB;
                else if (!tmo_hit) nxt = MEMRD;
            end
            MEMWB:  nxt = FETCH;
            MEMWR: begin
                if (!mem_ready && !tmo_hit) nxt = MEMWR;
            end
            EXEC:   nxt = ALUWB;
            ALUWB:  nxt = FETCH;
            BRANCH: nxt = FETCH;
            ADDIEX: nxt = ADDIWB;
            ADDIWB: nxt = FETCH;
            JUMP:   nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    // State, registered Moore word and consecutive-wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            ctl      <= moore(FETCH);
            wait_cnt <= '0;
        end else begin
            state <= nxt;
            ctl   <= moore(nxt);
            if ((MEM_TIMEOUT > 0) && wait_st && !mem_ready && !tmo_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // Output drive: everything forced low while reset is asserted.
    always_comb begin
        mem_req     = !reset && ctl.mem_req;
        iord        = !reset && ctl.iord;
        memtoreg    = !reset && ctl.memtoreg;
        regdst      = !reset && ctl.regdst;
        regwrite    = !reset && ctl.regwrite;
        alusrca     = !reset && ctl.alusrca;
        alusrcb     = reset ? 2'b00 : ctl.alusrcb;
        aluop       = reset ? 2'b00 : ctl.aluop;
        pcsrc       = reset ? 2'b00 : ctl.pcsrc;
        branch      = !reset && ctl.branch;
        irwrite     = !reset && (state == FETCH) && mem_ready;
        pcwrite     = !reset && (ctl.pcwrite || ((state == FETCH) && mem_ready));
        memwrite    = !reset && (state == MEMWR) && mem_ready;
        illegal_op  = !reset && (state == DECODE) && bad_op;
        mem_timeout = !reset && tmo_hit;
        state_o     = reset ? 4'd0 : state;
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: default config, no-jump config and a
// MEM_TIMEOUT=4 config run side by side on a shared clock.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [3];
    logic [5:0] op    [3];
    logic       rdy   [3];
    logic       mem_req[3], iord[3], irwrite[3], memwrite[3], memtoreg[3];
    logic       regdst[3], regwrite[3], alusrca[3], pcwrite[3], branch[3];
    logic       illegal_op[3], mem_timeout[3];
    logic [1:0] alusrcb[3], aluop[3], pcsrc[3];
    logic [3:0] state_o[3];

    logic [21:0] outs [3];
    logic [11:0] fl   [3];
    logic [4:0]  alu  [3];

    for (genvar g = 0; g < 3; g++) begin : g_pk
        assign outs[g] = {mem_req[g], iord[g], irwrite[g], memwrite[g], memtoreg[g],
                          regdst[g], regwrite[g], alusrca[g], alusrcb[g], aluop[g],
                          pcsrc[g], pcwrite[g], branch[g], illegal_op[g],
                          mem_timeout[g], state_o[g]};
        assign fl[g]   = {mem_req[g], iord[g], regwrite[g], memtoreg[g], memwrite[g],
                          branch[g], regdst[g], illegal_op[g], pcwrite[g], irwrite[g],
                          pcsrc[g]};
        assign alu[g]  = {alusrca[g], alusrcb[g], aluop[g]};
    end

    mc_ctrl_fsm u_dut (
        .clk(clk), .reset(rst[0]), .op(op[0]), .mem_ready(rdy[0]),
        .mem_req(mem_req[0]), .iord(iord[0]), .irwrite(irwrite[0]), .memwrite(memwrite[0]),
        .memtoreg(memtoreg[0]), .regdst(regdst[0]), .regwrite(regwrite[0]),
        .alusrca(alusrca[0]), .alusrcb(alusrcb[0]), .aluop(aluop[0]), .pcsrc(pcsrc[0]),
        .pcwrite(pcwrite[0]), .branch(branch[0]), .illegal_op(illegal_op[0]),
        .mem_timeout(mem_timeout[0]), .state_o(state_o[0])
    );

    mc_ctrl_fsm #(.SUPPORT_JUMP(0)) u_nj (
        .clk(clk), .reset(rst[1]), .op(op[1]), .mem_ready(rdy[1]),
        .mem_req(mem_req[1]), .iord(iord[1]), .irwrite(irwrite[1]), .memwrite(memwrite[1]),
        .memtoreg(memtoreg[1]), .regdst(regdst[1]), .regwrite(regwrite[1]),
        .alusrca(alusrca[1]), .alusrcb(alusrcb[1]), .aluop(aluop[1]), .pcsrc(pcsrc[1]),
        .pcwrite(pcwrite[1]), .branch(branch[1]), .illegal_op(illegal_op[1]),
        .mem_timeout(mem_timeout[1]), .state_o(state_o[1])
    );

    mc_ctrl_fsm #(.MEM_TIMEOUT(4)) u_to (
        .clk(clk), .reset(rst[2]), .op(op[2]), .mem_ready(rdy[2]),
        .mem_req(mem_req[2]), .iord(iord[2]), .irwrite(irwrite[2]), .memwrite(memwrite[2]),
        .memtoreg(memtoreg[2]), .regdst(regdst[2]), .regwrite(regwrite[2]),
        .alusrca(alusrca[2]), .alusrcb(alusrcb[2]), .aluop(aluop[2]), .pcsrc(pcsrc[2]),
        .pcwrite(pcwrite[2]), .branch(branch[2]), .illegal_op(illegal_op[2]),
        .mem_timeout(mem_timeout[2]), .state_o(state_o[2])
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected flag words {mem_req,iord,regwrite,memtoreg,memwrite,branch,
    // regdst,illegal_op,pcwrite,irwrite,pcsrc}.
    localparam logic [11:0] F_FET = 12'b100000001100;
    localparam logic [11:0] F_NON = 12'b000000000000;
    localparam logic [11:0] F_ILL = 12'b000000010000;
    localparam logic [11:0] F_MEM = 12'b110000000000;
    localparam logic [11:0] F_MWB = 12'b001100000000;
    localparam logic [11:0] F_MWR = 12'b110010000000;
    localparam logic [11:0] F_AWB = 12'b001000100000;
    localparam logic [11:0] F_IWB = 12'b001000000000;
    localparam logic [11:0] F_BRA = 12'b000001000001;
    localparam logic [11:0] F_JMP = 12'b000000001010;
    // Expected {alusrca,alusrcb,aluop}.
    localparam logic [4:0] A_FET = 5'b00100;
    localparam logic [4:0] A_DEC = 5'b01100;
    localparam logic [4:0] A_ADR = 5'b11000;
    localparam logic [4:0] A_EXE = 5'b10010;
    localparam logic [4:0] A_BRA = 5'b10001;
    localparam logic [4:0] A_NON = 5'b00000;

    typedef struct packed {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [11:0] fl;
        logic [4:0]  alu;
    } row_t;

    row_t q[$];

    task automatic add(input logic [5:0] o, input logic r, input logic [3:0] s,
                       input logic [11:0] f, input logic [4:0] a);
        row_t t;
        t.op = o; t.rdy = r; t.st = s; t.fl = f; t.alu = a;
        q.push_back(t);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; rdy[k] = 1'b1; op[k] = 6'd0;
        end
        // lw
        add(6'h23, 1, 0,  F_FET, A_FET);
        add(6'h23, 1, 1,  F_NON, A_DEC);
        add(6'h23, 1, 2,  F_NON, A_ADR);
        add(6'h23, 1, 3,  F_MEM, A_NON);
        add(6'h23, 1, 4,  F_MWB, A_NON);
        // sw with three wait cycles
        add(6'h2B, 1, 0,  F_FET, A_FET);
        add(6'h2B, 1, 1,  F_NON, A_DEC);
        add(6'h2B, 1, 2,  F_NON, A_ADR);
        add(6'h2B, 0, 5,  F_MEM, A_NON);
        add(6'h2B, 0, 5,  F_MEM, A_NON);
        add(6'h2B, 0, 5,  F_MEM, A_NON);
        add(6'h2B, 1, 5,  F_MWR, A_NON);
        // illegal opcode
        add(6'h3F, 1, 0,  F_FET, A_FET);
        add(6'h3F, 1, 1,  F_ILL, A_DEC);
        // beq, j, R-type, addi back to back
        add(6'h04, 1, 0,  F_FET, A_FET);
        add(6'h04, 1, 1,  F_NON, A_DEC);
        add(6'h04, 1, 8,  F_BRA, A_BRA);
        add(6'h02, 1, 0,  F_FET, A_FET);
        add(6'h02, 1, 1,  F_NON, A_DEC);
        add(6'h02, 1, 11, F_JMP, A_NON);
        add(6'h00, 1, 0,  F_FET, A_FET);
        add(6'h00, 1, 1,  F_NON, A_DEC);
        add(6'h00, 1, 6,  F_NON, A_EXE);
        add(6'h00, 1, 7,  F_AWB, A_NON);
        add(6'h08, 1, 0,  F_FET, A_FET);
        add(6'h08, 1, 1,  F_NON, A_DEC);
        add(6'h08, 1, 9,  F_NON, A_ADR);
        add(6'h08, 1, 10, F_IWB, A_NON);
        // lead into a store that gets reset while in MEMWR
        add(6'h2B, 1, 0,  F_FET, A_FET);
        add(6'h2B, 1, 1,  F_NON, A_DEC);
        add(6'h2B, 1, 2,  F_NON, A_ADR);

        // reset held for three sampled cycles
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_outs_dut", 32'(outs[0]), 32'd0);
            chk("rst_outs_to",  32'(outs[2]), 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        rdy[2] = 1'b0;

        fork
            begin : p_dut
                for (int i = 0; i < q.size(); i++) begin
                    op[0]  = q[i].op;
                    rdy[0] = q[i].rdy;
                    @(negedge clk);
                    chk($sformatf("st_%0d", i),  32'(state_o[0]), 32'(q[i].st));
                    chk($sformatf("fl_%0d", i),  32'(fl[0]),      32'(q[i].fl));
                    chk($sformatf("alu_%0d", i), 32'(alu[0]),     32'(q[i].alu));
                    chk($sformatf("tmo_%0d", i), 32'(mem_timeout[0]), 32'd0);
                    @(posedge clk); #1;
                end
                // now in MEMWR with ready: reset must suppress the write
                rst[0] = 1'b1;
                rdy[0] = 1'b1;
                @(negedge clk);
                chk("rst_mid_outs", 32'(outs[0]), 32'd0);
                @(posedge clk); #1;
                rst[0] = 1'b0;
                @(negedge clk);
                chk("rst_mid_st",  32'(state_o[0]), 32'd0);
                chk("rst_mid_fl",  32'(fl[0]),      32'(F_FET));
            end
            begin : p_nj
                for (int i = 0; i < 3; i++) begin
                    op[1] = 6'b000010;
                    @(negedge clk);
                    chk($sformatf("nj_st_%0d", i), 32'(state_o[1]), (i == 1) ? 32'd1 : 32'd0);
                    chk($sformatf("nj_fl_%0d", i), 32'(fl[1]),
                        (i == 1) ? 32'(F_ILL) : 32'(F_FET));
                    @(posedge clk); #1;
                end
            end
            begin : p_to
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    chk($sformatf("to_st_%0d", i),  32'(state_o[2]), 32'd0);
                    chk($sformatf("to_pul_%0d", i), 32'(mem_timeout[2]),
                        ((i % 4) == 3) ? 32'd1 : 32'd0);
                    chk($sformatf("to_irw_%0d", i), 32'(irwrite[2]), 32'd0);
                    chk($sformatf("to_pcw_%0d", i), 32'(pcwrite[2]), 32'd0);
                    @(posedge clk); #1;
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
